// File: rtl/mat_inst_fetch_pkg.sv
// Shared mat package: default instruction-memory geometry used by MatInstMem,
// MatControl and the fetch stage, plus the fetch FIFO entry layout.
package mat_inst_fetch_pkg;

    localparam int MAT_INST_MEM_SIZE       = 1024;
    localparam int MAT_INST_MEM_ADDR_SIZE  = 32;
    localparam int MAT_INST_MEM_WIDTH_SIZE = 128;
    localparam int MAT_FIFO_DEPTH          = 4;

    // One prefetched instruction together with the word index it came from.
    typedef struct packed {
        logic [MAT_INST_MEM_ADDR_SIZE-1:0]  addr;
        logic [MAT_INST_MEM_WIDTH_SIZE-1:0] inst;
    } MatFetchEntry_t;

endpackage

// File: rtl/mat_fetch_fifo.sv
// mat_fetch_fifo: synchronous FIFO of fetch entries with flush.
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   flush_i           empties the FIFO; overrides push and pop
//   push_i/wr_entry_i write an entry (accepted when not full, or full with pop)
//   pop_i             remove the head entry (ignored when empty)
//   head_o            head entry, read straight from storage registers
//   count_o           occupied entries; empty_o/full_o decoded from it
module mat_fetch_fifo
    import mat_inst_fetch_pkg::*;
#(
    parameter int  DEPTH   = MAT_FIFO_DEPTH,
    parameter type entry_t = MatFetchEntry_t,
    parameter int  COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  entry_t             wr_entry_i,
    output entry_t             head_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty_o = (count_q == COUNT_W'(0));
    assign full_o  = (count_q == COUNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop_s  = pop_i & !empty_o & !flush_i;
        // A full FIFO still takes a write when the head leaves in the same cycle.
        do_push_s = push_i & !flush_i & (!full_o | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/mat_inst_fetch.sv
// mat_inst_fetch: instruction prefetch stage between MatInstMem and MatControl.
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   inst_mem_read_addr    word index to MatInstMem (the fetch PC)
//   inst_mem_data_out     combinational read data for inst_mem_read_addr
//   inst_valid/ready/data/addr  head-of-FIFO handshake towards MatControl
//   redirect/redirect_addr      flush FIFO and load a new PC
//   halt                  level; stops new fetches, FIFO still drains
//   fifo_count            occupied prefetch entries
module mat_inst_fetch
    import mat_inst_fetch_pkg::*;
#(
    parameter int INST_MEM_SIZE       = MAT_INST_MEM_SIZE,
    parameter int INST_MEM_ADDR_SIZE  = MAT_INST_MEM_ADDR_SIZE,
    parameter int INST_MEM_WIDTH_SIZE = MAT_INST_MEM_WIDTH_SIZE,
    parameter int FIFO_DEPTH          = MAT_FIFO_DEPTH,
    parameter int COUNT_SIZE          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_mem_read_addr,
    input  logic [INST_MEM_WIDTH_SIZE-1:0] inst_mem_data_out,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [INST_MEM_WIDTH_SIZE-1:0] inst_data,
    output logic [INST_MEM_ADDR_SIZE-1:0]  inst_addr,
    input  logic                           redirect,
    input  logic [INST_MEM_ADDR_SIZE-1:0]  redirect_addr,
    input  logic                           halt,
    output logic [COUNT_SIZE-1:0]          fifo_count
);

    // Local entry type so non-default widths still pack correctly.
    typedef struct packed {
        logic [INST_MEM_ADDR_SIZE-1:0]  addr;
        logic [INST_MEM_WIDTH_SIZE-1:0] inst;
    } fetch_entry_t;

    localparam logic [INST_MEM_ADDR_SIZE-1:0] PC_LAST = INST_MEM_ADDR_SIZE'(INST_MEM_SIZE - 1);

    logic [INST_MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    logic                          push_s;
    logic                          pop_s;
    logic                          empty_s;
    logic                          full_s;
    fetch_entry_t                  wr_entry_s;
    fetch_entry_t                  head_s;

    assign inst_mem_read_addr = pc_q;
    assign inst_valid         = !empty_s;
    assign inst_data          = head_s.inst;
    assign inst_addr          = head_s.addr;
    assign wr_entry_s.addr    = pc_q;
    assign wr_entry_s.inst    = inst_mem_data_out;

    // Handshake and fetch decisions; redirect voids any pop and push.
    always_comb begin
        pop_s  = !empty_s & inst_ready & !redirect;
        push_s = !redirect & !halt & (!full_s | pop_s);
        pc_d   = pc_q;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (push_s) begin
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + INST_MEM_ADDR_SIZE'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    mat_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t),
        .COUNT_W (COUNT_SIZE)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (redirect),
        .push_i     (push_s),
        .pop_i      (pop_s),
        .wr_entry_i (wr_entry_s),
        .head_o     (head_s),
        .count_o    (fifo_count),
        .empty_o    (empty_s),
        .full_o     (full_s)
    );

endmodule

// File: tb/tb_mat_inst_fetch.sv
// Directed bench for mat_inst_fetch. Memory model: mem[k] = k (zero-extended).
// u_dut uses default geometry; u_dut8 has INST_MEM_SIZE=8 for PC wrap.
module tb_mat_inst_fetch;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  read_addr;
    logic [127:0] mem_data;
    logic         inst_valid;
    logic         inst_ready = 1'b1;
    logic [127:0] inst_data;
    logic [31:0]  inst_addr;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_addr = 32'd0;
    logic         halt = 1'b0;
    logic [2:0]   fifo_count;

    logic [31:0]  read_addr8;
    logic [127:0] mem_data8;
    logic         inst_valid8;
    logic [127:0] inst_data8;
    logic [31:0]  inst_addr8;
    logic         redirect8 = 1'b0;
    logic [31:0]  redirect_addr8 = 32'd0;
    logic [2:0]   fifo_count8;

    int checks   = 0;
    int failures = 0;

    assign mem_data  = 128'(read_addr);
    assign mem_data8 = 128'(read_addr8);

    always #5 clock = ~clock;

    mat_inst_fetch u_dut (
        .clock              (clock),
        .reset              (reset),
        .inst_mem_read_addr (read_addr),
        .inst_mem_data_out  (mem_data),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .inst_data          (inst_data),
        .inst_addr          (inst_addr),
        .redirect           (redirect),
        .redirect_addr      (redirect_addr),
        .halt               (halt),
        .fifo_count         (fifo_count)
    );

    mat_inst_fetch #(.INST_MEM_SIZE(8)) u_dut8 (
        .clock              (clock),
        .reset              (reset),
        .inst_mem_read_addr (read_addr8),
        .inst_mem_data_out  (mem_data8),
        .inst_valid         (inst_valid8),
        .inst_ready         (1'b1),
        .inst_data          (inst_data8),
        .inst_addr          (inst_addr8),
        .redirect           (redirect8),
        .redirect_addr      (redirect_addr8),
        .halt               (1'b0),
        .fifo_count         (fifo_count8)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b required=0", inst_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", fifo_count); end
        checks++; if (inst_data !== 128'd0) begin failures++; $display("FAIL reset_data actual=%0h required=0", inst_data); end
        checks++; if (inst_addr !== 32'd0) begin failures++; $display("FAIL reset_addr actual=%0d required=0", inst_addr); end
        checks++; if (read_addr !== 32'd0) begin failures++; $display("FAIL reset_rdaddr actual=%0d required=0", read_addr); end
    endtask

    // Test 1: ready always high, one new address per cycle from cycle 1.
    task automatic test_stream();
        logic [127:0] exp_data;
        inst_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step();
            exp_data = 128'(k);
            checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d actual=%0b required=1", k, inst_valid); end
            checks++; if (inst_addr !== 32'(k)) begin failures++; $display("FAIL stream_addr actual=%0d required=%0d", inst_addr, k); end
            checks++; if (inst_data !== exp_data) begin failures++; $display("FAIL stream_data actual=%0h required=%0h", inst_data, exp_data); end
            checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL stream_count actual=%0d required=1", fifo_count); end
        end
    endtask

    // Mid-stream async reset, then tests 2 and 3: backpressure fill and full streaming.
    task automatic test_backpressure();
        int exp_cnt;
        reset = 1'b1;
        #2;
        checks++; if (inst_valid !== 1'b0 || fifo_count !== 3'd0 || inst_addr !== 32'd0 || inst_data !== 128'd0 || read_addr !== 32'd0)
            begin failures++; $display("FAIL async_reset valid=%0b count=%0d addr=%0d data=%0h rdaddr=%0d required all 0", inst_valid, fifo_count, inst_addr, inst_data, read_addr); end
        checks++; if (read_addr8 !== 32'd0 || inst_valid8 !== 1'b0) begin failures++; $display("FAIL async_reset8 rdaddr=%0d valid=%0b required 0", read_addr8, inst_valid8); end
        inst_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_cnt = (i + 1 > 4) ? 4 : i + 1;
            checks++; if (fifo_count !== 3'(exp_cnt)) begin failures++; $display("FAIL bp_count i=%0d actual=%0d required=%0d", i, fifo_count, exp_cnt); end
            checks++; if (read_addr !== 32'(exp_cnt)) begin failures++; $display("FAIL bp_pc i=%0d actual=%0d required=%0d", i, read_addr, exp_cnt); end
            checks++; if (inst_addr !== 32'd0 || inst_valid !== 1'b1) begin failures++; $display("FAIL bp_head i=%0d addr=%0d valid=%0b required addr 0 valid 1", i, inst_addr, inst_valid); end
        end
        inst_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'(j)) begin failures++; $display("FAIL full_drain j=%0d addr=%0d valid=%0b required addr %0d valid 1", j, inst_addr, inst_valid, j); end
            checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count j=%0d actual=%0d required=4", j, fifo_count); end
            step();
        end
    endtask

    // Test 4: redirect while head is addr 2.
    task automatic test_redirect();
        inst_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (inst_addr !== 32'd2) begin failures++; $display("FAIL redir_pre_addr actual=%0d required=2", inst_addr); end
        redirect = 1'b1;
        redirect_addr = 32'd100;
        step();
        redirect = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL redir_count actual=%0d required=0", fifo_count); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_valid actual=%0b required=0", inst_valid); end
        checks++; if (read_addr !== 32'd100) begin failures++; $display("FAIL redir_rdaddr actual=%0d required=100", read_addr); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'd100 || inst_data !== 128'd100) begin failures++; $display("FAIL redir_target valid=%0b addr=%0d data=%0h required valid 1 addr 100", inst_valid, inst_addr, inst_data); end
        step();
        checks++; if (inst_addr !== 32'd101) begin failures++; $display("FAIL redir_next actual=%0d required=101", inst_addr); end
    endtask

    // Test 5: halt drains three entries, PC frozen; then halt together with redirect.
    task automatic test_halt();
        inst_ready = 1'b0;
        do_reset();
        step(); step(); step();
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL halt_fill actual=%0d required=3", fifo_count); end
        halt = 1'b1;
        inst_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'(j)) begin failures++; $display("FAIL halt_drain j=%0d addr=%0d valid=%0b required addr %0d valid 1", j, inst_addr, inst_valid, j); end
            step();
        end
        checks++; if (inst_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL halt_empty valid=%0b count=%0d required 0", inst_valid, fifo_count); end
        step();
        checks++; if (read_addr !== 32'd3 || inst_valid !== 1'b0) begin failures++; $display("FAIL halt_frozen pc=%0d valid=%0b required pc 3 valid 0", read_addr, inst_valid); end
        halt = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'd3) begin failures++; $display("FAIL halt_resume addr=%0d valid=%0b required addr 3 valid 1", inst_addr, inst_valid); end
        halt = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'd50;
        step();
        redirect = 1'b0;
        checks++; if (fifo_count !== 3'd0 || read_addr !== 32'd50) begin failures++; $display("FAIL halt_redir count=%0d pc=%0d required count 0 pc 50", fifo_count, read_addr); end
        step();
        checks++; if (inst_valid !== 1'b0 || read_addr !== 32'd50) begin failures++; $display("FAIL halt_redir_hold valid=%0b pc=%0d required valid 0 pc 50", inst_valid, read_addr); end
        halt = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'd50) begin failures++; $display("FAIL halt_redir_resume addr=%0d valid=%0b required addr 50 valid 1", inst_addr, inst_valid); end
    endtask

    // Test 6: INST_MEM_SIZE=8 instance, PC wraps 6,7,0,1.
    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'd6; exp_seq[1] = 32'd7; exp_seq[2] = 32'd0; exp_seq[3] = 32'd1;
        redirect8 = 1'b1;
        redirect_addr8 = 32'd6;
        step();
        redirect8 = 1'b0;
        checks++; if (read_addr8 !== 32'd6 || inst_valid8 !== 1'b0 || fifo_count8 !== 3'd0) begin failures++; $display("FAIL wrap_redir pc=%0d valid=%0b count=%0d required pc 6 valid 0 count 0", read_addr8, inst_valid8, fifo_count8); end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if (inst_valid8 !== 1'b1 || inst_addr8 !== exp_seq[j] || inst_data8 !== 128'(exp_seq[j])) begin failures++; $display("FAIL wrap_seq j=%0d addr=%0d data=%0h valid=%0b required addr %0d", j, inst_addr8, inst_data8, inst_valid8, exp_seq[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
